// File: rtl/axi4_lite_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_slave_regfile
//  Purpose  : AXI4-Lite slave register bank. A word-aligned address window is
//             decoded into p_NUM_REGS registers, each either read/write (value
//             exported on reg_o) or read-only (value taken live from sts_i).
//             One outstanding write and one outstanding read; the two paths
//             run independently of each other.
//  Ports    : ACLK/ARESETn          clock, async active-low reset
//             AW*/W*/B*             AXI4-Lite write address/data/response
//             AR*/R*                AXI4-Lite read address/data
//             reg_o                 RW register contents, reg i at [i*DW +: DW]
//             sts_i                 RO register sources, same packing
//             wr_pulse_o            1-cycle strobe per register on OKAY write
//  Revision : 1.0  initial release
// ============================================================================
module axi4_lite_slave_regfile #(
  parameter int                               p_ADDRESS_BUS_WIDTH = 32,
  parameter int                               p_DATA_BUS_WIDTH    = 32,
  parameter int                               p_NUM_REGS          = 16,
  parameter logic [p_ADDRESS_BUS_WIDTH-1:0]   p_BASE_ADDR         = '0,
  parameter logic [p_NUM_REGS-1:0]            p_RO_MASK           = '0,
  parameter logic [p_DATA_BUS_WIDTH-1:0]      p_RST_VAL           = '0
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETn,
  input  logic [p_ADDRESS_BUS_WIDTH-1:0]         AWADDR,
  input  logic [2:0]                             AWPROT,
  input  logic                                   AWVALID,
  output logic                                   AWREADY,
  input  logic [p_DATA_BUS_WIDTH-1:0]            WDATA,
  input  logic [p_DATA_BUS_WIDTH/8-1:0]          WSTRB,
  input  logic                                   WVALID,
  output logic                                   WREADY,
  output logic [1:0]                             BRESP,
  output logic                                   BVALID,
  input  logic                                   BREADY,
  input  logic [p_ADDRESS_BUS_WIDTH-1:0]         ARADDR,
  input  logic [2:0]                             ARPROT,
  input  logic                                   ARVALID,
  output logic                                   ARREADY,
  output logic [p_DATA_BUS_WIDTH-1:0]            RDATA,
  output logic [1:0]                             RRESP,
  output logic                                   RVALID,
  input  logic                                   RREADY,
  output logic [p_NUM_REGS*p_DATA_BUS_WIDTH-1:0] reg_o,
  input  logic [p_NUM_REGS*p_DATA_BUS_WIDTH-1:0] sts_i,
  output logic [p_NUM_REGS-1:0]                  wr_pulse_o
);

  localparam int AW   = p_ADDRESS_BUS_WIDTH;
  localparam int DW   = p_DATA_BUS_WIDTH;
  localparam int N    = p_NUM_REGS;
  localparam int SW   = DW / 8;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] WIN_BYTES = AW'(N * 4);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE = 1'b0, W_RESP = 1'b1 } wstate_t;
  typedef enum logic { R_IDLE = 1'b0, R_DATA = 1'b1 } rstate_t;

  wstate_t         w_state, w_next;
  rstate_t         r_state, r_next;

  logic            aw_held, w_held;
  logic [AW-1:0]   aw_addr_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic [DW-1:0]   regs [N];
  logic [1:0]      bresp_q, rresp_q;
  logic [DW-1:0]   rdata_q;
  logic [N-1:0]    wr_pulse_q;

  logic            aw_fire, w_fire, ar_fire, commit;
  logic [AW-1:0]   wr_addr, wr_off, rd_off;
  logic [DW-1:0]   wr_data;
  logic [SW-1:0]   wr_strb;
  logic            wr_hit, wr_ok, rd_hit;
  logic [IDXW-1:0] wr_idx, rd_idx;

  // Protection attributes carry no meaning for this bank.
  logic            unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT};

  assign AWREADY    = (w_state == W_IDLE) && !aw_held;
  assign WREADY     = (w_state == W_IDLE) && !w_held;
  assign BVALID     = (w_state == W_RESP);
  assign BRESP      = bresp_q;
  assign ARREADY    = (r_state == R_IDLE);
  assign RVALID     = (r_state == R_DATA);
  assign RDATA      = rdata_q;
  assign RRESP      = rresp_q;
  assign wr_pulse_o = wr_pulse_q;

  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID && WREADY;
  assign ar_fire = ARVALID && ARREADY;

  // A half captured earlier is used from its holding register; a half
  // arriving this cycle is used straight from the bus so the commit happens
  // on the edge of the later handshake.
  assign wr_addr = aw_held ? aw_addr_q : AWADDR;
  assign wr_data = w_held  ? wdata_q   : WDATA;
  assign wr_strb = w_held  ? wstrb_q   : WSTRB;
  assign commit  = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);

  // Address decode: the addr >= base term rejects addresses below the window
  // whose subtraction would otherwise wrap into it.
  assign wr_off = wr_addr - p_BASE_ADDR;
  assign wr_hit = (wr_addr >= p_BASE_ADDR) && (wr_off < WIN_BYTES);
  assign wr_idx = wr_off[IDXW+1:2];
  assign wr_ok  = wr_hit && !p_RO_MASK[wr_idx];

  assign rd_off = ARADDR - p_BASE_ADDR;
  assign rd_hit = (ARADDR >= p_BASE_ADDR) && (rd_off < WIN_BYTES);
  assign rd_idx = rd_off[IDXW+1:2];

  // ---------------- write FSM ----------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (commit) w_next = W_RESP;
      W_RESP:  if (BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_addr_q  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (aw_fire) aw_addr_q <= AWADDR;
      if (w_fire) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) wr_pulse_q[wr_idx] <= 1'b1;
      end else begin
        if (aw_fire) aw_held <= 1'b1;
        if (w_fire)  w_held  <= 1'b1;
      end
    end
  end

  // ---------------- register storage ----------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < N; i++) regs[i] <= p_RST_VAL;
    end else if (commit && wr_ok) begin
      for (int b = 0; b < SW; b++) begin
        if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_reg_o
      assign reg_o[gi*DW +: DW] = regs[gi];
    end
  endgenerate

  // ---------------- read FSM ----------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ARVALID) r_next = R_DATA;
      R_DATA:  if (RREADY)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read data is only loaded on the AR handshake, so it stays stable for as
  // long as RREADY is withheld. Same-edge writes are not visible here because
  // regs still holds the pre-commit value at this edge.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_fire) begin
      if (!rd_hit) begin
        rdata_q <= '0;
        rresp_q <= RESP_SLVERR;
      end else if (p_RO_MASK[rd_idx]) begin
        rdata_q <= sts_i[rd_idx*DW +: DW];
        rresp_q <= RESP_OKAY;
      end else begin
        rdata_q <= regs[rd_idx];
        rresp_q <= RESP_OKAY;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_lite_slave_regfile
//  Purpose  : Self-checking bench for axi4_lite_slave_regfile. Directed
//             scenarios with literal expectations plus randomized traffic,
//             all checked against a register-array model every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi4_lite_slave_regfile;

  localparam int          N    = 16;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [15:0] RO   = 16'h0088;

  logic         ACLK = 1'b0;
  logic         ARESETn;
  logic [31:0]  AWADDR, WDATA, ARADDR;
  logic [2:0]   AWPROT, ARPROT;
  logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic         ARVALID, ARREADY, RVALID, RREADY;
  logic [3:0]   WSTRB;
  logic [1:0]   BRESP, RRESP;
  logic [31:0]  RDATA;
  logic [N*32-1:0] reg_o, sts_bus;
  logic [N-1:0] wr_pulse_o;

  axi4_lite_slave_regfile #(
    .p_ADDRESS_BUS_WIDTH(32), .p_DATA_BUS_WIDTH(32), .p_NUM_REGS(N),
    .p_BASE_ADDR(BASE), .p_RO_MASK(RO), .p_RST_VAL(32'h0)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_o(reg_o), .sts_i(sts_bus), .wr_pulse_o(wr_pulse_o)
  );

  always #5 ACLK = ~ACLK;

  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] s; } wr_t;
  wr_t         wq[$];
  logic [31:0] rq[$];
  logic [31:0] mdl [N];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void decode(input logic [31:0] a, output bit hit, output int idx);
    logic [31:0] off;
    off = a - BASE;
    hit = (a >= BASE) && (off < N * 4);
    idx = int'(off >> 2);
  endfunction

  // -------- compare process: model vs DUT on every falling edge --------
  initial begin : compare
    bit          bprev, rprev, hit;
    int          idx;
    logic [31:0] exp_rd;
    logic [1:0]  exp_rr, exp_br;
    logic [N-1:0] exp_pulse;
    logic [N*32-1:0] sts_snap;
    wr_t         w;
    logic [31:0] ra;
    bprev = 0; rprev = 0; exp_rd = '0; exp_rr = '0; exp_br = '0;
    for (int i = 0; i < N; i++) mdl[i] = '0;
    sts_snap = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        for (int i = 0; i < N; i++) mdl[i] = '0;
        wq.delete(); rq.delete();
        bprev = 0; rprev = 0;
      end else begin
        chk("arready_vs_rvalid", ARREADY, !RVALID);
        if (BVALID) chk("aw_w_ready_while_bvalid", {AWREADY, WREADY}, 2'b00);
        // Reads see the model as it stood before this edge's write commit.
        if (RVALID && !rprev) begin
          if (rq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rvalid: got 1 expected 0 at %0t", $time);
          end else begin
            ra = rq.pop_front();
            decode(ra, hit, idx);
            if (!hit)         begin exp_rd = '0; exp_rr = 2'b10; end
            else if (RO[idx]) begin exp_rd = sts_snap[idx*32 +: 32]; exp_rr = 2'b00; end
            else              begin exp_rd = mdl[idx]; exp_rr = 2'b00; end
            chk("rdata", RDATA, exp_rd);
            chk("rresp", RRESP, exp_rr);
          end
        end else if (RVALID) begin
          chk("rdata_stable", RDATA, exp_rd);
          chk("rresp_stable", RRESP, exp_rr);
        end
        exp_pulse = '0;
        if (BVALID && !bprev) begin
          if (wq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_bvalid: got 1 expected 0 at %0t", $time);
          end else begin
            w = wq.pop_front();
            decode(w.a, hit, idx);
            if (hit && !RO[idx]) begin
              exp_br = 2'b00;
              exp_pulse[idx] = 1'b1;
              for (int b = 0; b < 4; b++) if (w.s[b]) mdl[idx][8*b +: 8] = w.d[8*b +: 8];
            end else begin
              exp_br = 2'b10;
            end
            chk("bresp", BRESP, exp_br);
          end
        end else if (BVALID) begin
          chk("bresp_stable", BRESP, exp_br);
        end
        chk("wr_pulse", wr_pulse_o, exp_pulse);
        for (int i = 0; i < N; i++)
          if (!RO[i]) chk($sformatf("reg_o[%0d]", i), reg_o[i*32 +: 32], mdl[i]);
        bprev = BVALID; rprev = RVALID;
      end
      sts_snap = sts_bus;
    end
  end

  // -------- bus tasks (drive at posedge+1, sample at negedge) --------
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int awd, input int wd, input int bd, output logic [1:0] resp);
    bit aw_done, w_done, aw_f, w_f;
    int c;
    wr_t e;
    e.a = a; e.d = d; e.s = s;
    wq.push_back(e);
    aw_done = 0; w_done = 0; c = 0; resp = 2'bxx;
    @(posedge ACLK); #1;
    while (!(aw_done && w_done) && c < 100) begin
      AWVALID = !aw_done && (c >= awd); AWADDR = a;
      WVALID  = !w_done && (c >= wd);   WDATA = d; WSTRB = s;
      @(negedge ACLK);
      aw_f = AWVALID && AWREADY; w_f = WVALID && WREADY;
      @(posedge ACLK); #1;
      if (aw_f) aw_done = 1;
      if (w_f)  w_done  = 1;
      c++;
    end
    AWVALID = 0; WVALID = 0;
    if (!(aw_done && w_done)) begin
      total++; bad++;
      $display("FAIL write_handshake_timeout: got 0 expected 1 at %0t", $time);
      return;
    end
    @(negedge ACLK);
    chk("bvalid_latency", BVALID, 1'b1);
    resp = BRESP;
    @(posedge ACLK); #1;
    for (int i = 0; i < bd; i++) begin
      AWVALID = 1; AWADDR = $urandom(); WVALID = 1; WDATA = $urandom();
      @(posedge ACLK); #1;
    end
    AWVALID = 0; WVALID = 0; BREADY = 1;
    @(posedge ACLK); #1;
    BREADY = 0;
    @(negedge ACLK);
    chk("bvalid_cleared", BVALID, 1'b0);
    chk("aw_w_ready_restored", {AWREADY, WREADY}, 2'b11);
  endtask

  task automatic do_read(input logic [31:0] a, input int ard, input int rd,
                         output logic [31:0] data, output logic [1:0] resp);
    bit done, f;
    int c;
    rq.push_back(a);
    done = 0; c = 0; data = 'x; resp = 2'bxx;
    @(posedge ACLK); #1;
    while (!done && c < 100) begin
      ARVALID = (c >= ard); ARADDR = a;
      @(negedge ACLK);
      f = ARVALID && ARREADY;
      @(posedge ACLK); #1;
      if (f) done = 1;
      c++;
    end
    ARVALID = 0;
    if (!done) begin
      total++; bad++;
      $display("FAIL read_handshake_timeout: got 0 expected 1 at %0t", $time);
      return;
    end
    @(negedge ACLK);
    chk("rvalid_latency", RVALID, 1'b1);
    data = RDATA; resp = RRESP;
    @(posedge ACLK); #1;
    for (int i = 0; i < rd; i++) begin
      ARVALID = 1; ARADDR = $urandom();
      @(posedge ACLK); #1;
    end
    ARVALID = 0; RREADY = 1;
    @(posedge ACLK); #1;
    RREADY = 0;
    @(negedge ACLK);
    chk("rvalid_cleared", RVALID, 1'b0);
    chk("arready_restored", ARREADY, 1'b1);
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return BASE + 32'd64 + (32'($urandom_range(0, 15)) << 2);
    if (k == 1) return BASE - 32'd4 * 32'($urandom_range(1, 4));
    return BASE + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {AWREADY, WREADY, ARREADY}, 3'b111);
    chk({tag, "_valid"}, {BVALID, RVALID}, 2'b00);
    chk({tag, "_resp"}, {BRESP, RRESP}, 4'b0000);
    chk({tag, "_rdata"}, RDATA, 32'h0);
    chk({tag, "_pulse"}, wr_pulse_o, '0);
    for (int i = 0; i < N; i++) chk({tag, "_reg_o"}, reg_o[i*32 +: 32], 32'h0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // -------- stimulus --------
  initial begin : stim
    logic [1:0]  br, rr;
    logic [31:0] rd;
    ARESETn = 0;
    AWADDR = '0; WDATA = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0; WSTRB = '0;
    AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
    sts_bus = '0;
    @(negedge ACLK);
    chk_reset_outputs("reset");
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1;

    // basic write/read
    do_write(BASE + 32'h4, 32'hA5A5_1234, 4'hF, 0, 0, 0, br);
    chk("t1_bresp", br, 2'b00);
    do_read(BASE + 32'h4, 0, 0, rd, rr);
    chk("t1_rdata", rd, 32'hA5A5_1234);
    chk("t1_rresp", rr, 2'b00);

    // byte strobes
    do_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, br);
    do_write(BASE + 32'h8, 32'h0000_0000, 4'b0101, 0, 0, 0, br);
    do_read(BASE + 32'h8, 0, 0, rd, rr);
    chk("t2_rdata", rd, 32'hFF00_FF00);
    do_write(BASE + 32'h8, 32'h1234_5678, 4'b0000, 0, 0, 0, br);
    chk("strb0_bresp", br, 2'b00);
    do_read(BASE + 32'h8, 0, 0, rd, rr);
    chk("strb0_rdata", rd, 32'hFF00_FF00);

    // read-only register
    @(posedge ACLK); #1 sts_bus[3*32 +: 32] = 32'hCAFE_0001;
    do_write(BASE + 32'hC, 32'h5555_5555, 4'hF, 0, 0, 0, br);
    chk("t3_bresp", br, 2'b10);
    do_read(BASE + 32'hC, 0, 0, rd, rr);
    chk("t3_rdata", rd, 32'hCAFE_0001);
    chk("t3_rresp", rr, 2'b00);

    // out of range, above and below the window
    do_write(BASE + 32'd64, 32'h1, 4'hF, 0, 0, 0, br);
    chk("t4_bresp_hi", br, 2'b10);
    do_read(BASE + 32'd64, 0, 0, rd, rr);
    chk("t4_rdata_hi", rd, 32'h0);
    chk("t4_rresp_hi", rr, 2'b10);
    do_write(BASE - 32'd4, 32'h1, 4'hF, 0, 0, 0, br);
    chk("t4_bresp_lo", br, 2'b10);

    // W three cycles early, long backpressure on both responses
    fork
      do_write(BASE + 32'h10, 32'h0BAD_F00D, 4'hF, 3, 0, 10, br);
      do_read(BASE + 32'h4, 0, 10, rd, rr);
    join
    chk("t5_bresp", br, 2'b00);
    chk("t5_rdata", rd, 32'hA5A5_1234);

    // same-edge read and write commit to one register
    do_write(BASE + 32'h14, 32'h1111_1111, 4'hF, 0, 0, 0, br);
    fork
      do_write(BASE + 32'h14, 32'h2222_2222, 4'hF, 0, 0, 0, br);
      do_read(BASE + 32'h14, 0, 0, rd, rr);
    join
    chk("same_edge_old", rd, 32'h1111_1111);
    do_read(BASE + 32'h14, 0, 0, rd, rr);
    chk("same_edge_new", rd, 32'h2222_2222);

    // randomized traffic
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge ACLK); #1;
        for (int i = 0; i < N; i++) sts_bus[i*32 +: 32] = $urandom();
      end
      case ($urandom_range(0, 2))
        0: do_write(rand_addr(), $urandom(), 4'($urandom()), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), br);
        1: do_read(rand_addr(), $urandom_range(0, 3), $urandom_range(0, 3), rd, rr);
        default: fork
          do_write(rand_addr(), $urandom(), 4'($urandom()), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), br);
          do_read(rand_addr(), $urandom_range(0, 3), $urandom_range(0, 3), rd, rr);
        join
      endcase
    end

    // reset with a write response pending
    do_write(BASE, 32'h1357_9BDF, 4'hF, 0, 0, 0, br);
    do_read(BASE, 0, 0, rd, rr);
    begin
      wr_t e;
      e.a = BASE + 32'h4; e.d = 32'hDEAD_BEEF; e.s = 4'hF;
      wq.push_back(e);
    end
    @(posedge ACLK); #1;
    AWVALID = 1; AWADDR = BASE + 32'h4; WVALID = 1; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF;
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0;
    @(negedge ACLK);
    chk("t6_bvalid_pending", BVALID, 1'b1);
    #2 ARESETn = 0;
    #1 chk_reset_outputs("t6_async");
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1;
    do_write(BASE + 32'h18, 32'h600D_CAFE, 4'hF, 0, 0, 0, br);
    chk("t6_bresp", br, 2'b00);
    do_read(BASE + 32'h18, 0, 0, rd, rr);
    chk("t6_rdata", rd, 32'h600D_CAFE);
    do_read(BASE + 32'h4, 0, 0, rd, rr);
    chk("t6_cleared", rd, 32'h0);

    repeat (3) @(posedge ACLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
